// File: rtl/fixed_point_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fixed_point_pkg : shared fixed-point defaults, word type and sequencer states
// Rev 1.0
// ----------------------------------------------------------------------------
package fixed_point_pkg;

    localparam int DEFAULT_WORD_LENGTH     = 6;
    localparam int DEFAULT_INTEGER_PART    = 3;
    localparam int DEFAULT_FRACTIONAL_PART = DEFAULT_WORD_LENGTH - DEFAULT_INTEGER_PART;

    typedef logic signed [DEFAULT_WORD_LENGTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } dot_state_t;

endpackage
`default_nettype wire

// File: rtl/Fixed_Point_MAC.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Fixed_Point_MAC : combinational D = trunc(A*B) + C, wrapping, no saturation
// Rev 1.0
// ----------------------------------------------------------------------------
module Fixed_Point_MAC #(
    parameter int WORD_LENGTH  = 6,
    parameter int INTEGER_PART = 3
) (
    input  logic signed [WORD_LENGTH-1:0] A,
    input  logic signed [WORD_LENGTH-1:0] B,
    input  logic signed [WORD_LENGTH-1:0] C,
    output logic signed [WORD_LENGTH-1:0] D
);

    localparam int FRACTIONAL_PART = WORD_LENGTH - INTEGER_PART;

    logic signed [2*WORD_LENGTH-1:0] product;
    logic signed [WORD_LENGTH-1:0]   trunc;

    assign product = A * B;
    // Arithmetic shift floors toward -inf; the cast drops the excess integer bits.
    assign trunc   = WORD_LENGTH'(product >>> FRACTIONAL_PART);
    assign D       = trunc + C;

endmodule
`default_nettype wire

// File: rtl/fixed_point_dot_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fixed_point_dot_seq : streamed dot product plus bias on one shared MAC
// Rev 1.0
// ----------------------------------------------------------------------------
module fixed_point_dot_seq
    import fixed_point_pkg::*;
#(
    parameter int WORD_LENGTH  = DEFAULT_WORD_LENGTH,
    parameter int INTEGER_PART = DEFAULT_INTEGER_PART,
    parameter int LEN_MAX      = 8,
    parameter int LEN_W        = $clog2(LEN_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [LEN_W-1:0]       len_i,
    input  logic [WORD_LENGTH-1:0] bias_i,
    output logic                   busy_o,
    input  logic [WORD_LENGTH-1:0] a_i,
    input  logic [WORD_LENGTH-1:0] b_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    output logic [WORD_LENGTH-1:0] result_o,
    output logic                   result_valid_o,
    input  logic                   result_ack_i
);

    dot_state_t              state;
    logic [WORD_LENGTH-1:0]  acc;
    logic [WORD_LENGTH-1:0]  mac_d;
    logic [LEN_W-1:0]        cnt;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        len_clamped;

    assign len_clamped = (len_i > LEN_W'(LEN_MAX)) ? LEN_W'(LEN_MAX) : len_i;

    Fixed_Point_MAC #(
        .WORD_LENGTH  (WORD_LENGTH),
        .INTEGER_PART (INTEGER_PART)
    ) u_mac (
        .A (a_i),
        .B (b_i),
        .C (acc),
        .D (mac_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        acc   <= bias_i;
                        cnt   <= '0;
                        len_q <= len_clamped;
                        state <= (len_clamped == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid_i) begin
                        acc <= mac_d;
                        cnt <= cnt + LEN_W'(1);
                        if (cnt == len_q - LEN_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (result_ack_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state and registers only, never from inputs.
    assign in_ready_o     = (state == ACCUM);
    assign result_valid_o = (state == DONE);
    assign busy_o         = (state == ACCUM) || (state == DONE);
    assign result_o       = (state == DONE) ? acc : '0;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_dot_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fixed_point_dot_seq : directed vectors with hand-computed results
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fixed_point_dot_seq;

    localparam int WL      = 6;
    localparam int LEN_MAX = 8;
    localparam int LEN_W   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic [WL-1:0] bias_i = '0;
    logic          busy_o;
    logic [WL-1:0] a_i = '0;
    logic [WL-1:0] b_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [WL-1:0] result_o;
    logic          result_valid_o;
    logic          result_ack_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    fixed_point_dot_seq #(
        .WORD_LENGTH  (WL),
        .INTEGER_PART (3),
        .LEN_MAX      (LEN_MAX),
        .LEN_W        (LEN_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .len_i          (len_i),
        .bias_i         (bias_i),
        .busy_o         (busy_o),
        .a_i            (a_i),
        .b_i            (b_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ack_i   (result_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int res();
        return int'($signed(result_o));
    endfunction

    task automatic start_op(input int len, input int bias);
        @(negedge clk);
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        bias_i  = WL'(bias);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic beat(input int a, input int b);
        a_i        = WL'(a);
        b_i        = WL'(b);
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic ack_result();
        result_ack_i = 1'b1;
        @(negedge clk);
        result_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int held;

        // Reset state
        #2;
        check("rst_ready", int'(in_ready_o), 0);
        check("rst_busy",  int'(busy_o), 0);
        check("rst_valid", int'(result_valid_o), 0);
        check("rst_result", res(), 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic: (8,8)+(16,4)+(-8,8) -> 8 + 8 - 8 = 8
        start_op(3, 0);
        check("basic_ready", int'(in_ready_o), 1);
        check("basic_busy",  int'(busy_o), 1);
        beat(8, 8);
        beat(16, 4);
        beat(-8, 8);
        check("basic_valid", int'(result_valid_o), 1);
        check("basic_result", res(), 8);
        check("basic_ready_done", int'(in_ready_o), 0);
        @(negedge clk);
        check("basic_hold", res(), 8);
        ack_result();
        check("basic_idle_valid", int'(result_valid_o), 0);
        check("basic_idle_busy", int'(busy_o), 0);

        // Wrap: 24*16=384 -> 48 -> -16
        start_op(1, 0);
        beat(24, 16);
        check("wrap1_result", res(), -16);
        ack_result();

        // Wrap on add: 8*16 -> 16, +20 = 36 -> -28
        start_op(1, 20);
        beat(8, 16);
        check("wrap2_result", res(), -28);
        ack_result();

        // Zero length goes straight to DONE with the bias
        start_op(0, -5);
        check("zero_valid", int'(result_valid_o), 1);
        check("zero_ready", int'(in_ready_o), 0);
        check("zero_result", res(), -5);
        ack_result();

        // Clamp: len 11 -> 8 beats of (8,1), each adds 1
        start_op(LEN_MAX + 3, 0);
        a_i = WL'(8);
        b_i = WL'(1);
        in_valid_i = 1'b1;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            if (result_valid_o) break;
            if (in_ready_o) accepted++;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        check("clamp_beats", accepted, LEN_MAX);
        check("clamp_valid", int'(result_valid_o), 1);
        check("clamp_result", res(), 8);
        ack_result();

        // Stalls with ignored start in ACCUM: 16 + 4 = 20
        start_op(2, 0);
        beat(16, 8);
        start_i = 1'b1;
        len_i   = LEN_W'(1);
        bias_i  = WL'(3);
        for (int i = 0; i < 3; i++) @(negedge clk);
        start_i = 1'b0;
        check("stall_ready", int'(in_ready_o), 1);
        check("stall_valid", int'(result_valid_o), 0);
        beat(8, 4);
        check("stall_result", res(), 20);

        // Delayed ack with start held in DONE; result must stay put
        start_i = 1'b1;
        held = 0;
        for (int i = 0; i < 5; i++) begin
            if (result_valid_o && res() == 20) held++;
            @(negedge clk);
        end
        check("ack_delay_stable", held, 5);
        ack_result();
        start_i = 1'b0;
        check("ack_start_ignored_busy", int'(busy_o), 0);
        @(negedge clk);
        check("ack_start_still_idle", int'(busy_o), 0);

        // Asynchronous reset mid-vector
        start_op(4, 7);
        beat(8, 8);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy",  int'(busy_o), 0);
        check("arst_ready", int'(in_ready_o), 0);
        check("arst_valid", int'(result_valid_o), 0);
        @(negedge clk);
        reset = 1'b1;
        start_op(1, 0);
        beat(8, 8);
        check("post_rst_valid", int'(result_valid_o), 1);
        check("post_rst_result", res(), 8);
        ack_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
